// File: rtl/dsp_mac_pkg.sv
// ---------------------------------------------------------------------------
// dsp_mac_pkg
//
// Shared types and constants for the DSP-slice MAC sequencer.
//
// Contents:
//   state_t      - sequencer FSM state encoding
//   OPM_FIRST    - X=M, Z=0    : first product of a job, discards old P
//   OPM_ACC      - X=M, Z=P    : accumulate a product onto P
//   OPM_HOLD     - X=0, Z=P    : bubble, P keeps its value
//   OPM_CLR      - X=0, Z=0    : P is cleared to zero
//   OPM_SUB_BIT  - post-adder subtract flag, bit 7 of OPMODE
// ---------------------------------------------------------------------------
package dsp_mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [7:0] OPM_FIRST   = 8'h01;
  localparam logic [7:0] OPM_ACC     = 8'h09;
  localparam logic [7:0] OPM_HOLD    = 8'h08;
  localparam logic [7:0] OPM_CLR     = 8'h00;
  localparam logic [7:0] OPM_SUB_BIT = 8'h80;

endpackage

// File: rtl/opm_dly_line.sv
// ---------------------------------------------------------------------------
// opm_dly_line
//
// Clock-enabled shift register of 8-bit OPMODE tags. It moves in lock-step
// with the slice pipeline, so a tag pushed with an operand beat comes out at
// the post-adder stage together with that beat's product.
//
// Parameters:
//   DEPTH    - number of stages (1..4 in practice)
//   RST_VAL  - value loaded into every stage by reset
//
// Ports:
//   clk   in   clock
//   rst   in   asynchronous, active-high reset
//   ce    in   shift enable; the line holds when low
//   din   in   tag entering stage 0
//   dout  out  tag leaving the last stage
// ---------------------------------------------------------------------------
module opm_dly_line #(
  parameter int         DEPTH   = 2,
  parameter logic [7:0] RST_VAL = 8'h08
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] stage [DEPTH];

  // Every stage resets to the hold tag so that P is left untouched while
  // the line refills after a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RST_VAL;
      end
    end else if (ce) begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/dsp_mac_seq.sv
// ---------------------------------------------------------------------------
// dsp_mac_seq
//
// Sequencer for a DSP-slice multiply-accumulate. It accepts a job of `len`
// operand beats, drives the common slice clock enable and produces the
// OPMODE sequence (first / accumulate / hold / clear) aligned to the
// post-adder stage, then pulses `done` once P holds the final sum.
// A job of zero beats clears P instead.
//
// Parameters:
//   LEN_W    - width of the beat-count field
//   OPM_DLY  - ce-qualified cycles from an operand beat to the post-adder
//              (legal range 1..4)
//
// Build option:
//   DSP_MAC_SEQ_SUB_EN - adds input `sub`; when set with start, every beat
//                        of that job uses post-adder subtract (OPMODE[7]).
//
// Ports:
//   clk       in   clock
//   rst       in   asynchronous, active-high reset
//   start     in   one-cycle job request (honoured only in IDLE)
//   len       in   number of operand beats, sampled with start
//   sub       in   subtract mode, sampled with start (option only)
//   in_valid  in   an operand pair is present at the slice inputs
//   in_ready  out  an operand beat is accepted this cycle
//   ce        out  clock enable for all slice pipeline registers
//   opmode    out  slice OPMODE, aligned to the post-adder stage
//   busy      out  sequencer is not in IDLE
//   done      out  one-cycle pulse, P holds the final result
// ---------------------------------------------------------------------------
module dsp_mac_seq
  import dsp_mac_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int OPM_DLY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
`ifdef DSP_MAC_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             in_ready,
  output logic             ce,
  output logic [7:0]       opmode,
  output logic             busy,
  output logic             done
);

  // DRAIN runs for OPM_DLY+1 cycles: the drain counter walks 0..OPM_DLY.
  localparam int         DCNT_W     = 3;
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(OPM_DLY);

  state_t              state, state_nxt;
  logic [LEN_W-1:0]    remaining, remaining_nxt;
  logic                first_beat, first_nxt;
  logic [DCNT_W-1:0]   drain_cnt, drain_nxt;
  logic                sub_r, sub_nxt;
  logic                sub_in;
  logic [7:0]          sub_mask;
  logic [7:0]          tag;

`ifdef DSP_MAC_SEQ_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // Subtract only applies to operand beats; bubbles and the clear beat
  // never carry it.
  assign sub_mask = {sub_r, 7'b0};

  // State and job-context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      first_beat <= 1'b0;
      drain_cnt  <= '0;
      sub_r      <= 1'b0;
    end else begin
      state      <= state_nxt;
      remaining  <= remaining_nxt;
      first_beat <= first_nxt;
      drain_cnt  <= drain_nxt;
      sub_r      <= sub_nxt;
    end
  end

  // Next-state and output decode. ce is high for every cycle that pushes a
  // tag; an idle in_valid in RUN stalls the whole slice pipeline together
  // with the tag line, so P and the in-flight tags stay aligned.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    first_nxt     = first_beat;
    drain_nxt     = '0;
    sub_nxt       = sub_r;
    in_ready      = 1'b0;
    ce            = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    tag           = OPM_HOLD;

    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          sub_nxt = sub_in;
          if (len != '0) begin
            state_nxt     = ST_RUN;
            remaining_nxt = len;
            first_nxt     = 1'b1;
          end else begin
            state_nxt = ST_CLR;
          end
        end
      end

      ST_CLR: begin
        ce        = 1'b1;
        tag       = OPM_CLR;
        state_nxt = ST_DRAIN;
      end

      ST_RUN: begin
        in_ready = 1'b1;
        ce       = in_valid;
        tag      = (first_beat ? OPM_FIRST : OPM_ACC) | sub_mask;
        if (in_valid) begin
          // Counting down to one (rather than to zero) means the full
          // 2^LEN_W-1 range works without a wider counter.
          remaining_nxt = remaining - 1'b1;
          first_nxt     = 1'b0;
          if (remaining == LEN_W'(1)) begin
            state_nxt = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        ce  = 1'b1;
        tag = OPM_HOLD;
        if (drain_cnt == DRAIN_LAST) begin
          state_nxt = ST_DONE;
        end else begin
          drain_nxt = drain_cnt + 1'b1;
        end
      end

      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  opm_dly_line #(
    .DEPTH   (OPM_DLY),
    .RST_VAL (OPM_HOLD)
  ) u_dly (
    .clk  (clk),
    .rst  (rst),
    .ce   (ce),
    .din  (tag),
    .dout (opmode)
  );

endmodule

// File: doc/dsp_mac_seq.md
DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

Interface
REQ-001 SHALL have parameter LEN_W, default 8, the width of the beat-count field.
REQ-002 SHALL have parameter OPM_DLY, default 2, legal range 1..4: the number of ce-qualified cycles from an operand beat to its use at the post-adder.
REQ-003 SHALL have port clk, input, 1 bit, the clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle request to begin an accumulation.
REQ-006 SHALL have port len, input, LEN_W bits: the number of operand beats, sampled with start.
REQ-007 SHALL have port in_valid, input, 1 bit: an operand pair is present at the slice inputs.
REQ-008 SHALL have port in_ready, output, 1 bit: the sequencer accepts an operand beat this cycle.
REQ-009 SHALL have port ce, output, 1 bit: the common clock enable for all slice pipeline registers.
REQ-010 SHALL have port opmode, output, 8 bits: the slice OPMODE, aligned to the post-adder stage.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port done, output, 1 bit: a one-cycle pulse indicating P holds the final result.

Function
REQ-013 SHALL implement the states IDLE, CLR, RUN, DRAIN and DONE.
REQ-014 IDLE transitions: start with len>0 goes to RUN and loads remaining=len; start with len==0 goes to CLR.
REQ-015 start SHALL be ignored in every state except IDLE.
REQ-016 Beat acceptance: in_ready=1 only in RUN; a beat is accepted when in_valid&in_ready.
REQ-017 ce SHALL equal (RUN&in_valid) | CLR | DRAIN; it SHALL be 0 in IDLE and DONE, and in RUN when in_valid=0 (whole-pipeline stall).
REQ-018 Each ce cycle SHALL push one tag into an OPM_DLY-deep ce-gated delay line; opmode SHALL be the delay-line output.
REQ-019 Tag values: first beat 0x01 (X=M, Z=0); later beats 0x09 (X=M, Z=P); DRAIN bubble 0x08 (X=0, Z=P, hold); CLR beat 0x00 (P cleared to 0).
REQ-020 In RUN, each accepted beat SHALL decrement remaining; the beat accepted at remaining==1 SHALL move the FSM to DRAIN.
REQ-021 CLR SHALL last exactly one cycle and then go to DRAIN.
REQ-022 DRAIN SHALL last exactly OPM_DLY+1 cycles and then go to DONE.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-024 Latency: done SHALL assert OPM_DLY+2 cycles after the last accepted beat.
REQ-025 Between DONE and the next start, P SHALL be stable because ce=0.
REQ-026 The beat counter SHALL NOT wrap; len=2^LEN_W-1 SHALL be supported.

Reset
REQ-027 While rst is asserted: state=IDLE, remaining=0, all delay-line stages=0x08, in_ready=0, ce=0, done=0, busy=0.
REQ-028 opmode SHALL read 0x08 during and after reset.
REQ-029 rst mid-operation SHALL abandon the job with no done pulse; P content is then undefined to the consumer.

Configuration
REQ-030 With macro DSP_MAC_SEQ_SUB_EN defined, SHALL add input port sub (1 bit) sampled with start; opmode[7] SHALL be sub for all beats of that job (post-adder subtract), and bubbles and the CLR beat SHALL keep bit7=0.
REQ-031 Without DSP_MAC_SEQ_SUB_EN, port sub SHALL be absent and opmode[7]=0 always.

Structure
REQ-032 Package dsp_mac_pkg SHALL hold the state enum type and the OPMODE constants (OPM_FIRST, OPM_ACC, OPM_HOLD, OPM_CLR).
REQ-033 Sub-module opm_dly_line SHALL be a parameterised, ce-gated, asynchronously reset shift register of 8-bit tags; it is the only sub-module.

Verification
REQ-034 Scenario: start, len=3, in_valid held 1, OPM_DLY=2 -> opmode sequence 0x01,0x09,0x09 then 0x08 bubbles; done exactly 4 cycles after the third beat.
REQ-035 Scenario: start, len=0 -> CLR, opmode 0x00 reaches the output, done after OPM_DLY+2 cycles, P=0.
REQ-036 Scenario: len=4 with in_valid low for 3 cycles after beat 2 -> ce=0 and opmode frozen during the stall; done 3 cycles later than the unstalled case.
REQ-037 Scenario: start pulsed again during RUN -> ignored; remaining unchanged; single done pulse.
REQ-038 Scenario: rst asserted in DRAIN -> immediately IDLE, opmode=0x08, no done; a following start with len=2 completes normally.
REQ-039 Scenario (SUB_EN): start with sub=1, len=2 -> beat tags 0x81,0x89; bubbles 0x08.
